unlock_rate_mon: RTL

//  Consumes the saturating 32-bit unlock-event count produced by the MMCM/PLL

---
 rtl/unlock_rate_mon.sv | 75 +++++++
 1 files changed

// File: rtl/unlock_rate_mon.sv
// unlock_rate_mon: turns a saturating unlock-event count into per-window delta, max, count and alarm
module unlock_rate_mon #(
  parameter int WINDOW_CYCLES = 100_000_000,
  parameter int DELTA_W       = 16
) (
  input  logic               clk_ref,
  input  logic               reset,
  input  logic [31:0]        unlocks,
  input  logic               enable,
  input  logic [DELTA_W-1:0] threshold,
  input  logic               clr_req,
  output logic               clr_ack,
  output logic [DELTA_W-1:0] win_delta,
  output logic [DELTA_W-1:0] win_max,
  output logic [31:0]        win_count,
  output logic               win_done,
  output logic               alarm
);
  localparam int TW = $clog2(WINDOW_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(WINDOW_CYCLES - 1);
  localparam logic [31:0] SAT_MAX = 32'({DELTA_W{1'b1}});
  typedef enum logic [1:0] {INIT, RUN, CLEAR} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0] baseline_q, baseline_d, raw;
  logic [DELTA_W-1:0] sat, win_delta_q, win_delta_d, win_max_q, win_max_d;
  logic [31:0] win_count_q, win_count_d;
  logic win_done_q, win_done_d, alarm_q, alarm_d, clr_ack_q, clr_ack_d, win_end, clearing;
  // next state, window-close arithmetic and statistic updates
  always_comb begin
    raw = (unlocks >= baseline_q) ? unlocks - baseline_q : unlocks;
    sat = (raw > SAT_MAX) ? '1 : raw[DELTA_W-1:0];
    win_end = state_q == RUN && timer_q == LAST && !clr_req && enable;
    state_d = clr_req ? CLEAR : (state_q == CLEAR) ? INIT : enable ? RUN : INIT;
    clearing = state_d == CLEAR;
    timer_d = (state_q == RUN && !win_end) ? timer_q + TW'(1) : '0;
    baseline_d = (state_q == INIT || win_end) ? unlocks : baseline_q;
    win_delta_d = clearing ? '0 : win_end ? sat : win_delta_q;
    win_max_d = clearing ? '0 : (win_end && sat > win_max_q) ? sat : win_max_q;
    win_count_d = clearing ? '0 : (win_end && !(&win_count_q)) ? win_count_q + 32'd1 : win_count_q;
    alarm_d = clearing ? 1'b0 : alarm_q | (win_end && threshold != '0 && sat > threshold);
    win_done_d = win_end;
    clr_ack_d = clearing;
  end
  // state and statistic registers, synchronous active-low reset
  always_ff @(posedge clk_ref) begin
    if (!reset) begin
      state_q     <= INIT;
      timer_q     <= '0;
      baseline_q  <= '0;
      win_delta_q <= '0;
      win_max_q   <= '0;
      win_count_q <= '0;
      win_done_q  <= 1'b0;
      alarm_q     <= 1'b0;
      clr_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      baseline_q  <= baseline_d;
      win_delta_q <= win_delta_d;
      win_max_q   <= win_max_d;
      win_count_q <= win_count_d;
      win_done_q  <= win_done_d;
      alarm_q     <= alarm_d;
      clr_ack_q   <= clr_ack_d;
    end
  end
  assign win_delta = win_delta_q;
  assign win_max   = win_max_q;
  assign win_count = win_count_q;
  assign win_done  = win_done_q;
  assign alarm     = alarm_q;
  assign clr_ack   = clr_ack_q;
endmodule
